// File: rtl/seg_capture.sv
// seg_capture: samples a seven-segment bus plus decimal point, waits for the
// pattern to settle, decodes it to a hex digit and reports each newly stable
// pattern once over a VALID/READY handshake.
// Optional build macro: SEG_CAPTURE_ACTIVE_LOW_EN inverts S/DP at the
// synchronizer input for common-anode displays.
//
// state | meaning
// EMPTY | no report pending, watching for a new stable pattern
// FULL  | report pending on VAL/ERR/DPO, waiting for READY
module seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] S,
  input  logic       DP,
  input  logic       READY,
  output logic       VALID,
  output logic [3:0] VAL,
  output logic       ERR,
  output logic       DPO
);

  localparam logic [7:0] cntMax = 8'(STABLE_CYCLES);

  typedef enum logic {EMPTY, FULL} stateT;

  stateT      state, stateNext;
  logic [7:0] syncIn;
  logic [7:0] s1, s2;
  logic [7:0] cand, last;
  logic [7:0] cnt;
  logic       first;
  logic       load;

  // Inversion sits ahead of s1 so a floating-high active-low bus reads as blank.
`ifdef SEG_CAPTURE_ACTIVE_LOW_EN
  assign syncIn = ~{S, DP};
`else
  assign syncIn = {S, DP};
`endif

  // Returns {err, val} for a segment pattern; unknown patterns decode to 0 with err.
  function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h7E:   r = 5'h00;
      7'h30:   r = 5'h01;
      7'h6D:   r = 5'h02;
      7'h79:   r = 5'h03;
      7'h33:   r = 5'h04;
      7'h5B:   r = 5'h05;
      7'h5F:   r = 5'h06;
      7'h70:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h7B:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h1F:   r = 5'h0B;
      7'h4E:   r = 5'h0C;
      7'h3D:   r = 5'h0D;
      7'h4F:   r = 5'h0E;
      7'h47:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  // Two-flop synchronizer for the asynchronous display lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 8'h00;
      s2 <= 8'h00;
    end else begin
      s1 <= syncIn;
      s2 <= s1;
    end
  end

  // Stability tracker: restart on any change, otherwise count up to the threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= 8'h00;
      cnt  <= 8'h00;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= 8'h00;
    end else if (cnt != cntMax) begin
      cnt  <= cnt + 8'd1;
    end
  end

  // Next-state: report a stable pattern that differs from the last one (or the first after reset).
  always_comb begin
    stateNext = state;
    load      = 1'b0;
    case (state)
      EMPTY: begin
        if (cnt == cntMax && (first || cand != last)) begin
          stateNext = FULL;
          load      = 1'b1;
        end
      end
      FULL: begin
        if (READY) stateNext = EMPTY;
      end
    endcase
  end

  // State register and report registers; report fields only change on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      VAL   <= 4'h0;
      ERR   <= 1'b0;
      DPO   <= 1'b0;
      last  <= 8'h00;
      first <= 1'b1;
    end else begin
      state <= stateNext;
      if (load) begin
        {ERR, VAL} <= decodeSeg(cand[7:1]);
        DPO        <= cand[0];
        last       <= cand;
        first      <= 1'b0;
      end
    end
  end

  assign VALID = (state == FULL);

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a sample-history model.
module tb_seg_capture;

  localparam int SC = 4;
`ifdef SEG_CAPTURE_ACTIVE_LOW_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] segL = 7'h00;
  logic       dpL = 1'b0;
  logic       READY = 1'b0;
  logic [6:0] S;
  logic       DP;
  logic       VALID;
  logic [3:0] VAL;
  logic       ERR;
  logic       DPO;

  int checks = 0;
  int errors = 0;

  // Bench works with logical (active-high) patterns; drive the bus in the configured polarity.
  assign S  = segL ^ {7{INV}};
  assign DP = dpL ^ INV;

  seg_capture #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .S(S), .DP(DP), .READY(READY),
    .VALID(VALID), .VAL(VAL), .ERR(ERR), .DPO(DPO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] legalPat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [7:0] dly  [$];
  logic [7:0] hist [$];
  logic       mValid, mErr, mDpo, mFirst;
  logic [3:0] mVal;
  logic [7:0] mLast;

  task automatic modelReset();
    dly    = '{8'h00, 8'h00};
    hist   = '{8'h00};
    mValid = 1'b0;
    mVal   = 4'h0;
    mErr   = 1'b0;
    mDpo   = 1'b0;
    mLast  = 8'h00;
    mFirst = 1'b1;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        modelReset();
      end else begin
        bit stable;
        stable = (hist.size() == SC + 1);
        foreach (hist[i]) if (hist[i] != hist[$]) stable = 1'b0;
        if (mValid) begin
          if (READY) mValid = 1'b0;
        end else if (stable && (mFirst || hist[$] != mLast)) begin
          mValid = 1'b1;
          mErr   = 1'b1;
          mVal   = 4'h0;
          for (int i = 0; i < 16; i++)
            if (legalPat[i] == hist[$][7:1]) begin
              mVal = 4'(i);
              mErr = 1'b0;
            end
          mDpo   = hist[$][0];
          mLast  = hist[$];
          mFirst = 1'b0;
        end
        hist.push_back(dly[0]);
        if (hist.size() > SC + 1) void'(hist.pop_front());
        void'(dly.pop_front());
        dly.push_back({segL, dpL});
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("valid", {7'd0, VALID}, {7'd0, mValid});
    if (mValid || rst) begin
      check("val", {4'd0, VAL}, {4'd0, mVal});
      check("err", {7'd0, ERR}, {7'd0, mErr});
      check("dpo", {7'd0, DPO}, {7'd0, mDpo});
    end
  end

  // Report monitor used by the directed literal checks.
  int         pulseCnt = 0;
  logic [3:0] capVal = 4'h0;
  logic       capErr = 1'b0;
  logic       capDpo = 1'b0;
  always @(posedge clk) begin
    #1;
    if (VALID) begin
      pulseCnt++;
      capVal = VAL;
      capErr = ERR;
      capDpo = DPO;
    end
  end

  logic [6:0] pool [19] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47,
                            7'h00, 7'h55, 7'h7C};

  initial begin
    // Reset state, then first report lands after edge k+7 (k = first edge after release).
    segL = 7'h7E; dpL = 1'b0; READY = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {7'd0, VALID}, 8'h00);
    check("rst_val", {4'd0, VAL}, 8'h00);
    #2 rst = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      check("first_valid", {7'd0, VALID}, (i == 8) ? 8'h01 : 8'h00);
      if (i == 8) begin
        check("first_val", {4'd0, VAL}, 8'h00);
        check("first_err", {7'd0, ERR}, 8'h00);
        check("first_dpo", {7'd0, DPO}, 8'h00);
      end
    end

    // Backpressure holds the report; one READY cycle clears it without a repeat.
    segL = 7'h79; READY = 1'b0;
    repeat (20) @(negedge clk);
    check("hold_valid", {7'd0, VALID}, 8'h01);
    check("hold_val", {4'd0, VAL}, 8'h03);
    READY = 1'b1;
    @(negedge clk);
    READY = 1'b0;
    check("accept_valid", {7'd0, VALID}, 8'h00);
    repeat (10) @(negedge clk);
    check("norepeat_valid", {7'd0, VALID}, 8'h00);

    // Short glitch back to the last reported pattern gives no report.
    READY = 1'b1; segL = 7'h30;
    repeat (12) @(negedge clk);
    pulseCnt = 0;
    segL = 7'h33;
    repeat (3) @(negedge clk);
    segL = 7'h30;
    repeat (15) @(negedge clk);
    check("glitch_reports", 8'(pulseCnt), 8'h00);

    // DP participates in the pattern.
    pulseCnt = 0; segL = 7'h47; dpL = 1'b1;
    repeat (12) @(negedge clk);
    check("dp1_reports", 8'(pulseCnt), 8'h01);
    check("dp1_val", {4'd0, capVal}, 8'h0F);
    check("dp1_dpo", {7'd0, capDpo}, 8'h01);
    pulseCnt = 0; dpL = 1'b0;
    repeat (12) @(negedge clk);
    check("dp0_reports", 8'(pulseCnt), 8'h01);
    check("dp0_val", {4'd0, capVal}, 8'h0F);
    check("dp0_dpo", {7'd0, capDpo}, 8'h00);

    // Illegal patterns decode with ERR.
    pulseCnt = 0; segL = 7'h00;
    repeat (12) @(negedge clk);
    check("blank_reports", 8'(pulseCnt), 8'h01);
    check("blank_err", {7'd0, capErr}, 8'h01);
    check("blank_val", {4'd0, capVal}, 8'h00);
    pulseCnt = 0; segL = 7'h55;
    repeat (12) @(negedge clk);
    check("x55_reports", 8'(pulseCnt), 8'h01);
    check("x55_err", {7'd0, capErr}, 8'h01);
    check("x55_val", {4'd0, capVal}, 8'h00);

    // Reset mid-handshake drops the report at once; the same pattern reports again.
    READY = 1'b0; segL = 7'h1F;
    repeat (12) @(negedge clk);
    check("pre_rst_valid", {7'd0, VALID}, 8'h01);
    #2 rst = 1'b1;
    #1 check("async_rst_valid", {7'd0, VALID}, 8'h00);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check("rerpt_valid", {7'd0, VALID}, (i >= 8) ? 8'h01 : 8'h00);
    end
    check("rerpt_val", {4'd0, VAL}, 8'h0B);

    // Randomized phase checked by the model.
    for (int n = 0; n < 600; n++) begin
      int hold;
      segL = pool[$urandom_range(0, 18)];
      if ($urandom_range(0, 3) == 0) dpL = ~dpL;
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        READY = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    READY = 1'b1;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
